// File: rtl/gpu_pc_pkg.sv
// rtl/gpu_pc_pkg.sv - shared types for the warp PC scheduler
package gpu_pc_pkg;

  typedef enum logic [2:0] {
    NEXT   = 3'd0,
    BRANCH = 3'd1,
    CALL   = 3'd2,
    RET    = 3'd3,
    HALT   = 3'd4
  } pc_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READY  = 2'd1,
    WAIT   = 2'd2,
    HALTED = 2'd3
  } warp_state_t;

  typedef enum logic [1:0] {
    NONE      = 2'd0,
    OVERFLOW  = 2'd1,
    UNDERFLOW = 2'd2
  } pc_err_t;

  function automatic int wid_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/warp_pc_scheduler_if.sv
// rtl/warp_pc_scheduler_if.sv - fetch issue handshake and execute-stage update bus
interface warp_pc_scheduler_if #(
  parameter int A = 8,
  parameter int W = 2
);
  logic         issue_valid;
  logic         issue_ready;
  logic [W-1:0] issue_warp;
  logic [A-1:0] issue_pc;
  logic         upd_valid;
  logic [W-1:0] upd_warp;
  logic [2:0]   upd_op;
  logic [A-1:0] upd_target;

  modport master (
    output issue_valid, issue_warp, issue_pc,
    input  issue_ready, upd_valid, upd_warp, upd_op, upd_target
  );

  modport slave (
    input  issue_valid, issue_warp, issue_pc,
    output issue_ready, upd_valid, upd_warp, upd_op, upd_target
  );
endinterface

// File: rtl/pc_return_stack.sv
// rtl/pc_return_stack.sv - per-warp return address stack; push when full / pop when empty are no-ops
module pc_return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] top
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_count == CW'(i + 1)) top = r_mem[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (push && !full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_count == CW'(i)) r_mem[i] <= push_data;
      end
      r_count <= r_count + CW'(1);
    end else if (pop && !empty) begin
      r_count <= r_count - CW'(1);
    end
  end
endmodule

// File: rtl/warp_pc_scheduler.sv
// rtl/warp_pc_scheduler.sv - per-warp PCs and return stacks with round-robin issue to fetch
module warp_pc_scheduler
  import gpu_pc_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int NUM_WARPS             = 4,
  parameter int STACK_DEPTH           = 4,
  localparam int A  = PROGRAM_MEM_ADDR_BITS,
  localparam int W  = wid_bits(NUM_WARPS),
  localparam int NW = $clog2(NUM_WARPS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [A-1:0]          start_pc,
  input  logic [NW-1:0]         num_active_warps,
  warp_pc_scheduler_if.master   bus,
  output logic                  err_valid,
  output logic [W-1:0]          err_warp,
  output logic [1:0]            err_code,
  output logic                  busy,
  output logic                  done
);
  warp_state_t r_state [NUM_WARPS];
  logic [A-1:0] r_pc   [NUM_WARPS];
  logic [W-1:0] r_rr;
  logic [W-1:0] r_lock_warp;
  logic         r_lock;
  logic         r_started;
  logic         r_done;
  logic         r_err_valid;
  logic [W-1:0] r_err_warp;
  pc_err_t      r_err_code;

  logic [NUM_WARPS-1:0] w_ready, w_wait, w_hit, w_push, w_pop, w_full, w_empty;
  logic [A-1:0]         w_top [NUM_WARPS];
  logic [W-1:0]         w_sel, w_issue_warp;
  logic                 w_any_ready, w_valid, w_fire, w_start_ok;
  logic [NW-1:0]        w_n;
  pc_op_t               w_op;

  assign w_op = pc_op_t'(bus.upd_op);
  assign w_n  = (num_active_warps > NW'(NUM_WARPS)) ? NW'(NUM_WARPS) : num_active_warps;

  always_comb begin
    for (int i = 0; i < NUM_WARPS; i++) begin
      w_ready[i] = (r_state[i] == READY);
      w_wait[i]  = (r_state[i] == WAIT);
      w_hit[i]   = bus.upd_valid && (bus.upd_warp == W'(i)) && w_wait[i];
      w_push[i]  = w_hit[i] && (w_op == CALL) && !w_full[i];
      w_pop[i]   = w_hit[i] && (w_op == RET) && !w_empty[i];
    end
  end

  // Scan downwards so the READY warp closest to the pointer wins last.
  always_comb begin : rr_select
    int idx;
    idx         = 0;
    w_sel       = '0;
    w_any_ready = 1'b0;
    for (int k = NUM_WARPS - 1; k >= 0; k--) begin
      idx = (int'(r_rr) + k) % NUM_WARPS;
      if (w_ready[W'(idx)]) begin
        w_sel       = W'(idx);
        w_any_ready = 1'b1;
      end
    end
  end

  assign w_valid         = r_lock | w_any_ready;
  assign w_issue_warp    = r_lock ? r_lock_warp : w_sel;
  assign w_fire          = w_valid & bus.issue_ready;
  assign busy            = |(w_ready | w_wait);
  assign w_start_ok      = start & ~busy;
  assign bus.issue_valid = w_valid;
  assign bus.issue_warp  = w_valid ? w_issue_warp : '0;
  assign bus.issue_pc    = w_valid ? r_pc[w_issue_warp] : '0;

  assign err_valid = r_err_valid;
  assign err_warp  = r_err_warp;
  assign err_code  = r_err_code;
  assign done      = r_done;

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_stack
    pc_return_stack #(.DEPTH(STACK_DEPTH), .WIDTH(A)) u_stack (
      .clk       (clk),
      .reset     (reset),
      .clear     (w_start_ok),
      .push      (w_push[g]),
      .pop       (w_pop[g]),
      .push_data (r_pc[g] + A'(1)),
      .full      (w_full[g]),
      .empty     (w_empty[g]),
      .top       (w_top[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        r_state[i] <= IDLE;
        r_pc[i]    <= '0;
      end
      r_rr        <= '0;
      r_lock      <= 1'b0;
      r_lock_warp <= '0;
      r_started   <= 1'b0;
      r_done      <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_warp  <= '0;
      r_err_code  <= NONE;
    end else begin
      r_err_valid <= 1'b0;
      r_err_warp  <= '0;
      r_err_code  <= NONE;
      if (w_start_ok) begin
        // Nothing is READY/WAIT here, so no issue or update can collide with launch.
        for (int i = 0; i < NUM_WARPS; i++) begin
          r_state[i] <= (i < int'(w_n)) ? READY : IDLE;
          r_pc[i]    <= start_pc;
        end
        r_rr      <= '0;
        r_lock    <= 1'b0;
        r_started <= 1'b1;
        r_done    <= (w_n == '0);
      end else begin
        r_done <= r_started & ~busy;
        if (w_fire) begin
          r_lock <= 1'b0;
          r_rr   <= (int'(w_issue_warp) == NUM_WARPS - 1) ? '0 : w_issue_warp + W'(1);
        end else if (w_valid) begin
          r_lock      <= 1'b1;
          r_lock_warp <= w_issue_warp;
        end
        for (int i = 0; i < NUM_WARPS; i++) begin
          if (w_fire && (w_issue_warp == W'(i))) begin
            r_state[i] <= WAIT;
          end else if (w_hit[i]) begin
            case (w_op)
              NEXT: begin
                r_pc[i]    <= r_pc[i] + A'(1);
                r_state[i] <= READY;
              end
              BRANCH: begin
                r_pc[i]    <= bus.upd_target;
                r_state[i] <= READY;
              end
              CALL: begin
                if (w_full[i]) begin
                  r_state[i]  <= HALTED;
                  r_err_valid <= 1'b1;
                  r_err_warp  <= W'(i);
                  r_err_code  <= OVERFLOW;
                end else begin
                  r_pc[i]    <= bus.upd_target;
                  r_state[i] <= READY;
                end
              end
              RET: begin
                if (w_empty[i]) begin
                  r_state[i]  <= HALTED;
                  r_err_valid <= 1'b1;
                  r_err_warp  <= W'(i);
                  r_err_code  <= UNDERFLOW;
                end else begin
                  r_pc[i]    <= w_top[i];
                  r_state[i] <= READY;
                end
              end
              default: r_state[i] <= HALTED;
            endcase
          end
        end
      end
    end
  end
endmodule
